hash_core_ctrl: RTL and testbench

Parametrised register front end and command sequencer for a block-hash core (SHA-512 class, init/next/ready/digest_valid handshake). Sits between the axi_lite_interface word port and the hash core. Generalised in bus, block, digest and mode width. Adds what a flat register map lacks: a busy/done/error sequencer, a digest capture register, and write protection while the core is busy.

---
 rtl/hash_core_ctrl.sv | 172 +++++++++++++++++
 tb/tb_hash_core_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hash_core_ctrl
// Register front end and init/next command sequencer for a block-hash core.
// Optional : HASH_CTRL_WIPE_EN zeroes the BLOCK registers when done is set.
// Revision : 1.0
// ============================================================================
module hash_core_ctrl #(
    parameter int BUS_W    = 64,
    parameter int BLOCK_W  = 1024,
    parameter int DIGEST_W = 512,
    parameter int MODE_W   = 2,
    parameter int ADDR_W   = 64,
    parameter int ADDR_LSB = 3,
    parameter int IDX_W    = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [7:0]          reglk_ctrl_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   address_i,
    input  logic [BUS_W-1:0]    wdata_i,
    output logic [BUS_W-1:0]    rdata_o,
    output logic                core_init_o,
    output logic                core_next_o,
    output logic [MODE_W-1:0]   core_mode_o,
    output logic [BLOCK_W-1:0]  core_block_o,
    input  logic                core_ready_i,
    input  logic [DIGEST_W-1:0] core_digest_i,
    input  logic                core_digest_valid_i
);

    localparam int NB       = BLOCK_W / BUS_W;
    localparam int ND       = DIGEST_W / BUS_W;
    localparam int BLK_BASE = 2;
    localparam int DIG_BASE = BLK_BASE + NB;
    localparam int DIG_END  = DIG_BASE + ND;
`ifdef HASH_CTRL_WIPE_EN
    localparam bit WIPE = 1'b1;
`else
    localparam bit WIPE = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state, state_nxt;
    logic [BUS_W-1:0]      blk [NB];
    logic [DIGEST_W-1:0]   digest;
    logic [MODE_W-1:0]     mode;
    logic                  err, done, cmd_init;
    logic [1:0]            ack_cnt;

    logic [IDX_W-1:0]      idx;
    int                    idx_n, blk_word;
    logic                  sel_ctrl, sel_mode, sel_blk, sel_dig;
    logic                  wr, ctrl_wr, mode_wr, blk_wr, cmd, cmd_go;
    logic                  busy, ack_timeout, capture, err_set;
    logic                  unused_ok;

    assign idx      = address_i[ADDR_LSB +: IDX_W];
    assign idx_n    = {{(32-IDX_W){1'b0}}, idx};
    assign blk_word = idx_n - BLK_BASE;
    assign sel_ctrl = (idx_n == 0);
    assign sel_mode = (idx_n == 1);
    assign sel_blk  = (idx_n >= BLK_BASE) && (idx_n < DIG_BASE);
    assign sel_dig  = (idx_n >= DIG_BASE) && (idx_n < DIG_END);

    // Locked writes vanish silently; only unlocked writes can raise err.
    assign wr      = en_i & we_i;
    assign ctrl_wr = wr & sel_ctrl & ~reglk_ctrl_i[1];
    assign mode_wr = wr & sel_mode & ~reglk_ctrl_i[1];
    assign blk_wr  = wr & sel_blk  & ~reglk_ctrl_i[3];
    assign cmd     = ctrl_wr & (wdata_i[0] | wdata_i[1]);

    assign busy        = (state != IDLE);
    assign cmd_go      = cmd & ~busy & core_ready_i;
    assign ack_timeout = (state == WAIT_ACK) && core_ready_i && (ack_cnt == 2'd3);
    assign capture     = (state == WAIT_DONE) && core_ready_i && core_digest_valid_i;
    assign err_set     = (busy & (mode_wr | blk_wr | cmd))
                       | (cmd & ~busy & ~core_ready_i)
                       | ack_timeout;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        core_init_o = 1'b0;
        core_next_o = 1'b0;
        case (state)
            IDLE:      if (cmd_go) state_nxt = ISSUE;
            ISSUE: begin
                core_init_o = cmd_init;
                core_next_o = ~cmd_init;
                state_nxt   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!core_ready_i)  state_nxt = WAIT_DONE;
                else if (ack_timeout) state_nxt = IDLE;
            end
            WAIT_DONE: if (capture) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err      <= 1'b0;
            done     <= 1'b0;
            cmd_init <= 1'b0;
            ack_cnt  <= 2'd0;
            mode     <= '0;
            digest   <= '0;
            for (int k = 0; k < NB; k++) blk[k] <= '0;
        end else begin
            // A fresh error outranks a simultaneous CLR_ERR.
            if (err_set)                     err <= 1'b1;
            else if (ctrl_wr && wdata_i[2])  err <= 1'b0;

            if (cmd_go)       done <= 1'b0;
            else if (capture) done <= 1'b1;

            if (cmd_go) cmd_init <= wdata_i[0];

            if (state == WAIT_ACK) ack_cnt <= ack_cnt + 2'd1;
            else                   ack_cnt <= 2'd0;

            if (mode_wr && !busy) mode <= wdata_i[MODE_W-1:0];
            if (capture)          digest <= core_digest_i;

            if (WIPE && capture) begin
                for (int k = 0; k < NB; k++) blk[k] <= '0;
            end else if (blk_wr && !busy) begin
                for (int k = 0; k < NB; k++)
                    if (blk_word == k) blk[k] <= wdata_i;
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        if (en_i) begin
            if (sel_ctrl && !reglk_ctrl_i[0])
                rdata_o = {{(BUS_W-4){1'b0}}, err, done, busy, core_ready_i};
            if (sel_mode && !reglk_ctrl_i[1])
                rdata_o = BUS_W'(mode);
            if (sel_blk && !reglk_ctrl_i[2])
                for (int k = 0; k < NB; k++)
                    if (blk_word == k) rdata_o = blk[k];
            if (sel_dig && !reglk_ctrl_i[4])
                for (int k = 0; k < ND; k++)
                    if (idx_n == DIG_BASE + k) rdata_o = digest[k*BUS_W +: BUS_W];
        end
    end

    for (genvar k = 0; k < NB; k++) begin : g_pack
        assign core_block_o[k*BUS_W +: BUS_W] = blk[k];
    end

    assign core_mode_o = mode;
    assign unused_ok   = ^{reglk_ctrl_i[7:5], address_i, wdata_i};

endmodule
`default_nettype wire

// File: tb/tb_hash_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hash_core_ctrl
// Self-checking bench: register vector table plus sequencer corner cases.
// Revision : 1.0
// ============================================================================
module tb_hash_core_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   reglk;
    logic         en, we;
    logic [63:0]  addr, wdata, rdata;
    logic         core_init, core_next;
    logic [1:0]   core_mode;
    logic [1023:0] core_block;
    logic         core_ready, core_valid;
    logic [511:0] dig;

    int           passed = 0;
    int           total  = 0;
    int           n_init = 0;
    int           n_next = 0;
    int           ctr    = 0;
    bit           stuck  = 1'b0;
    logic [63:0]  sb [$];

    hash_core_ctrl dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .reglk_ctrl_i        (reglk),
        .en_i                (en),
        .we_i                (we),
        .address_i           (addr),
        .wdata_i             (wdata),
        .rdata_o             (rdata),
        .core_init_o         (core_init),
        .core_next_o         (core_next),
        .core_mode_o         (core_mode),
        .core_block_o        (core_block),
        .core_ready_i        (core_ready),
        .core_digest_i       (dig),
        .core_digest_valid_i (core_valid)
    );

    always #5 clk = ~clk;

    // Core model: ready drops the cycle after a pulse, digest valid 80 cycles later.
    always @(posedge clk) begin
        if (!rst_n) begin
            core_ready <= 1'b1;
            core_valid <= 1'b0;
            ctr        <= 0;
        end else if (core_init || core_next) begin
            if (!stuck) begin
                core_ready <= 1'b0;
                core_valid <= 1'b0;
                ctr        <= 80;
            end
        end else if (ctr == 1) begin
            core_ready <= 1'b1;
            core_valid <= 1'b1;
            ctr        <= 0;
        end else if (ctr > 1) begin
            ctr <= ctr - 1;
        end
        if (core_init) n_init <= n_init + 1;
        if (core_next) n_next <= n_next + 1;
    end

    typedef struct {
        int          idx;
        bit          wr;
        logic [63:0] wd;
        logic [7:0]  lk;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(int i, bit w, logic [63:0] d, logic [7:0] l, logic [63:0] e);
        vec_t v;
        v.idx = i; v.wr = w; v.wd = d; v.lk = l; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic acc(input int idx, input bit w, input logic [63:0] d, output logic [63:0] r);
        @(negedge clk);
        en    = 1'b1;
        we    = w;
        addr  = 64'(idx) << 3;
        wdata = d;
        #1 r  = rdata;
        @(posedge clk);
        #1;
        en = 1'b0;
        we = 1'b0;
    endtask

    task automatic rd_chk(input int idx, input logic [63:0] exp, input string name);
        logic [63:0] r;
        logic [63:0] e;
        sb.push_back(exp);
        acc(idx, 1'b0, 64'h0, r);
        e = sb.pop_front();
        check(name, r, e);
    endtask

    task automatic wr(input int idx, input logic [63:0] d);
        logic [63:0] r;
        acc(idx, 1'b1, d, r);
    endtask

    initial begin
        logic [63:0] r;
        logic [63:0] blk2_exp;
        int          i0, n0;
        bit          got;

        for (int k = 0; k < 8; k++) dig[k*64 +: 64] = 64'hD16E_5700_0000_0000 | 64'(k * 17 + 3);
        rst_n = 1'b0; reglk = 8'h00; en = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        tbl.push_back(mk(0,  0, 64'h0, 8'h00, 64'h1));
        tbl.push_back(mk(1,  0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(2,  0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(17, 0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(18, 0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(25, 0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(40, 0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(1,  1, 64'h3, 8'h00, 64'h0));
        tbl.push_back(mk(1,  0, 64'h0, 8'h00, 64'h3));
        tbl.push_back(mk(1,  1, 64'hFFFF_FFFF_FFFF_FFFE, 8'h00, 64'h0));
        tbl.push_back(mk(1,  0, 64'h0, 8'h00, 64'h2));
        tbl.push_back(mk(17, 1, 64'hA5A5_5A5A_0F0F_F0F0, 8'h00, 64'h0));
        tbl.push_back(mk(17, 0, 64'h0, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0));
        tbl.push_back(mk(40, 1, 64'h1234, 8'h00, 64'h0));
        tbl.push_back(mk(40, 0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(18, 1, 64'h55, 8'h00, 64'h0));
        tbl.push_back(mk(18, 0, 64'h0, 8'h00, 64'h0));
        tbl.push_back(mk(0,  0, 64'h0, 8'h01, 64'h0));
        tbl.push_back(mk(1,  0, 64'h0, 8'h02, 64'h0));
        tbl.push_back(mk(1,  1, 64'h1, 8'h02, 64'h0));
        tbl.push_back(mk(1,  0, 64'h0, 8'h00, 64'h2));
        tbl.push_back(mk(17, 0, 64'h0, 8'h04, 64'h0));
        tbl.push_back(mk(17, 1, 64'h0, 8'h08, 64'h0));
        tbl.push_back(mk(17, 0, 64'h0, 8'h00, 64'hA5A5_5A5A_0F0F_F0F0));
        tbl.push_back(mk(0,  1, 64'h1, 8'h02, 64'h0));
        tbl.push_back(mk(0,  0, 64'h0, 8'h00, 64'h1));

        foreach (tbl[i]) begin
            reglk = tbl[i].lk;
            if (tbl[i].wr) wr(tbl[i].idx, tbl[i].wd);
            else           rd_chk(tbl[i].idx, tbl[i].exp, $sformatf("tbl%0d_idx%0d", i, tbl[i].idx));
        end
        reglk = 8'h00;
        check("mode_port", 64'(core_mode), 64'h2);
        check("block_port_w15", core_block[15*64 +: 64], 64'hA5A5_5A5A_0F0F_F0F0);
        repeat (20) @(posedge clk);
        #1 check("no_pulse_idle", 64'(n_init + n_next), 64'h0);

        // START with one block word loaded
        wr(2, 64'h0123_4567_89AB_CDEF);
        i0 = n_init;
        wr(0, 64'h1);
        check("init_pulse", 64'(core_init), 64'h1);
        rd_chk(0, 64'h3, "ctrl_issue");
        check("init_one_cycle", 64'(core_init), 64'h0);
        check("block_port_w0", core_block[63:0], 64'h0123_4567_89AB_CDEF);
        wr(3, 64'hDEAD_BEEF);
        wr(0, 64'h2);
        rd_chk(0, 64'hA, "ctrl_busy_err");
        rd_chk(3, 64'h0, "blk3_locked_busy");
        check("block_port_w1", core_block[127:64], 64'h0);
        wr(0, 64'h4);
        rd_chk(0, 64'h2, "ctrl_err_cleared");
        got = 1'b0;
        for (int k = 0; k < 300 && !got; k++) begin
            acc(0, 1'b0, 64'h0, r);
            if (r[2]) got = 1'b1;
        end
        check("done_wait", 64'(got), 64'h1);
        rd_chk(0, 64'h5, "ctrl_done");
        rd_chk(18, dig[63:0], "digest_w0");
        rd_chk(25, dig[511:448], "digest_w7");
        check("one_init", 64'(n_init - i0), 64'h1);
        check("no_next", 64'(n_next), 64'h0);
`ifdef HASH_CTRL_WIPE_EN
        blk2_exp = 64'h0;
`else
        blk2_exp = 64'h0123_4567_89AB_CDEF;
`endif
        rd_chk(2, blk2_exp, "blk2_after_done");

        // Locks 2/3/4
        reglk = 8'h1C;
        wr(2, 64'hFF);
        rd_chk(2, 64'h0, "blk2_read_locked");
        rd_chk(18, 64'h0, "digest_read_locked");
        rd_chk(0, 64'h5, "ctrl_no_err_lock");
        reglk = 8'h00;
        rd_chk(2, blk2_exp, "blk2_write_locked");

        // Core that never acknowledges
        stuck = 1'b1;
        i0 = n_init;
        wr(0, 64'h1);
        for (int k = 0; k < 5; k++) rd_chk(0, 64'h3, $sformatf("ack_wait%0d", k));
        rd_chk(0, 64'h9, "ack_timeout_err");
        check("timeout_one_init", 64'(n_init - i0), 64'h1);
        wr(0, 64'h4);
        stuck = 1'b0;
        rd_chk(0, 64'h1, "ctrl_after_clr");

        // Reset while waiting for the digest
        wr(0, 64'h2);
        check("next_pulse", 64'(core_next), 64'h1);
        repeat (10) @(posedge clk);
        rd_chk(0, 64'h2, "ctrl_wait_done");
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        i0 = n_init; n0 = n_next;
        rd_chk(0, 64'h1, "ctrl_after_rst");
        rd_chk(18, 64'h0, "digest_after_rst");
        rd_chk(2, 64'h0, "blk2_after_rst");
        repeat (20) @(posedge clk);
        #1 check("no_pulse_after_rst", 64'((n_init - i0) + (n_next - n0)), 64'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
